// File: rtl/uart_pkg.sv
// uart_pkg: shared UART types and defaults for the TX/RX pair
package uart_pkg;
   typedef enum logic [2:0] {IDLE, START, DATA, STOP, WAIT_IDLE} uart_rx_state_t;
   localparam int UART_DATA_BITS      = 8;
   localparam int UART_DEFAULT_CLK_FQ = 50_000_000;
   localparam int UART_DEFAULT_BAUD   = 115_200;
endpackage

// File: rtl/uart_sync2.sv
// uart_sync2: two-flop synchronizer for an asynchronous single-bit input
module uart_sync2 #(
   parameter logic rst_val = 1'b1
) (
   input  logic clk,
   input  logic rst,
   input  logic d,
   output logic q
);
   logic meta;
   // capture into meta, then move to q, both preset to the idle level
   always_ff @(posedge clk or negedge rst)
      if (!rst) {q, meta} <= {2{rst_val}};
      else      {q, meta} <= {meta, d};
endmodule

// File: rtl/uart_rx.sv
// uart_rx: 8N1 serial receiver with mid-bit sampling and a valid/ack holding register
module uart_rx
   import uart_pkg::*;
#(
   parameter int clk_fq    = UART_DEFAULT_CLK_FQ,
   parameter int baud_rate = UART_DEFAULT_BAUD,
   parameter int div_cnt   = clk_fq / baud_rate,
   parameter int half_cnt  = div_cnt / 2
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic                      rxd,
   output logic [UART_DATA_BITS-1:0] rxdata,
   output logic                      rx_valid,
   input  logic                      rx_ack,
   output logic                      busy,
   output logic                      frame_err,
   output logic                      overrun
);
   localparam int cw = $clog2(div_cnt);
   logic                      rxd_s;
   logic                      tick;
   uart_rx_state_t            state;
   logic [cw-1:0]             cnt;
   logic [2:0]                bit_idx;
   logic [UART_DATA_BITS-1:0] shreg;

   uart_sync2 #(.rst_val(1'b1)) u_sync (.clk(clk), .rst(rst), .d(rxd), .q(rxd_s));

   assign busy = state != IDLE;
   assign tick = (state == START) ? cnt == cw'(half_cnt - 1) : cnt == cw'(div_cnt - 1);

   // frame FSM, bit timing, shift register and output handshake
   always_ff @(posedge clk or negedge rst)
      if (!rst) begin
         state     <= IDLE;
         cnt       <= '0;
         bit_idx   <= '0;
         shreg     <= '0;
         rxdata    <= '0;
         rx_valid  <= 1'b0;
         frame_err <= 1'b0;
         overrun   <= 1'b0;
      end else begin
         frame_err <= 1'b0;
         overrun   <= 1'b0;
         if (rx_ack && rx_valid) rx_valid <= 1'b0;
         case (state)
            IDLE:
               if (!rxd_s) begin
                  state <= START;
                  cnt   <= '0;
               end
            START:
               if (tick) begin
                  cnt     <= '0;
                  bit_idx <= '0;
                  state   <= rxd_s ? IDLE : DATA;
               end else cnt <= cnt + cw'(1);
            DATA:
               if (tick) begin
                  cnt   <= '0;
                  shreg <= {rxd_s, shreg[UART_DATA_BITS-1:1]};
                  if (bit_idx == 3'd7) state <= STOP;
                  else bit_idx <= bit_idx + 3'd1;
               end else cnt <= cnt + cw'(1);
            STOP:
               if (tick) begin
                  cnt <= '0;
                  if (rxd_s) begin
                     rxdata   <= shreg;
                     rx_valid <= 1'b1;
                     overrun  <= rx_valid && !rx_ack;
                     state    <= IDLE;
                  end else begin
                     frame_err <= 1'b1;
                     state     <= WAIT_IDLE;
                  end
               end else cnt <= cnt + cw'(1);
            WAIT_IDLE:
               if (rxd_s) state <= IDLE;
            default:
               state <= IDLE;
         endcase
      end
endmodule

// File: tb/tb_uart_rx.sv
// tb_uart_rx: directed frame tests for uart_rx at 16 clocks per bit
module tb_uart_rx;
   logic       clk = 1'b0;
   logic       rst = 1'b0;
   logic       rxd = 1'b1;
   logic       rx_ack = 1'b0;
   logic [7:0] rxdata;
   logic       rx_valid, busy, frame_err, overrun;
   int         n_cmp = 0, n_err = 0;
   int         cyc = 0, start_cyc = 0, rise_cyc = -1000;
   int         fe_tot = 0, ov_tot = 0;
   logic       prev_valid = 1'b0;

   uart_rx #(.clk_fq(160), .baud_rate(10)) dut (
      .clk(clk), .rst(rst), .rxd(rxd), .rxdata(rxdata), .rx_valid(rx_valid),
      .rx_ack(rx_ack), .busy(busy), .frame_err(frame_err), .overrun(overrun)
   );

   always #5 clk = ~clk;

   // negedge monitor: cycle count, pulse totals, rx_valid rising time
   always @(negedge clk) begin
      cyc = cyc + 1;
      if (frame_err) fe_tot = fe_tot + 1;
      if (overrun) ov_tot = ov_tot + 1;
      if (rx_valid && !prev_valid) rise_cyc = cyc;
      prev_valid = rx_valid;
   end

   task automatic send_frame(input logic [7:0] b, input logic stop_bit);
      logic [9:0] f;
      f = {stop_bit, b, 1'b0};
      for (int i = 0; i < 10; i++) begin
         @(posedge clk);
         #1 rxd = f[i];
         if (i == 0) start_cyc = cyc;
         repeat (15) @(posedge clk);
      end
   endtask

   task automatic ack_pulse;
      @(negedge clk) rx_ack = 1'b1;
      @(negedge clk) rx_ack = 1'b0;
   endtask

   task automatic test_reset;
      @(negedge clk);
      n_cmp += 5;
      if (rxdata !== 8'h00) begin n_err++; $display("FAIL reset_rxdata got=%h exp=00", rxdata); end
      if (rx_valid !== 1'b0) begin n_err++; $display("FAIL reset_valid got=%b exp=0", rx_valid); end
      if (busy !== 1'b0) begin n_err++; $display("FAIL reset_busy got=%b exp=0", busy); end
      if (frame_err !== 1'b0) begin n_err++; $display("FAIL reset_ferr got=%b exp=0", frame_err); end
      if (overrun !== 1'b0) begin n_err++; $display("FAIL reset_ovr got=%b exp=0", overrun); end
      @(posedge clk) #1 rst = 1'b1;
      repeat (4) @(posedge clk);
   endtask

   task automatic test_single;
      int fe0, ov0;
      fe0 = fe_tot; ov0 = ov_tot;
      send_frame(8'hA5, 1'b1);
      repeat (4) @(posedge clk);
      @(negedge clk);
      n_cmp += 5;
      // T0 is the third negedge after the line drop; rx_valid is seen 153 cycles later
      if (rise_cyc - start_cyc !== 156) begin n_err++; $display("FAIL single_latency got=%0d exp=156", rise_cyc - start_cyc); end
      if (rxdata !== 8'hA5) begin n_err++; $display("FAIL single_data got=%h exp=a5", rxdata); end
      if (rx_valid !== 1'b1) begin n_err++; $display("FAIL single_valid got=%b exp=1", rx_valid); end
      if (fe_tot - fe0 !== 0) begin n_err++; $display("FAIL single_ferr got=%0d exp=0", fe_tot - fe0); end
      if (ov_tot - ov0 !== 0) begin n_err++; $display("FAIL single_ovr got=%0d exp=0", ov_tot - ov0); end
      ack_pulse();
      n_cmp++;
      if (rx_valid !== 1'b0) begin n_err++; $display("FAIL single_ack got=%b exp=0", rx_valid); end
      ack_pulse();
      n_cmp++;
      if (rxdata !== 8'hA5) begin n_err++; $display("FAIL idle_ack_data got=%h exp=a5", rxdata); end
   endtask

   task automatic test_glitch;
      int r0;
      r0 = rise_cyc;
      @(posedge clk) #1 rxd = 1'b0;
      for (int n = 1; n <= 14; n++) begin
         @(negedge clk);
         if (n == 5) rxd = 1'b1;
         if (n == 3) begin n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL glitch_t0_busy got=%b exp=0", busy); end end
         if (n == 4) begin n_cmp++; if (busy !== 1'b1) begin n_err++; $display("FAIL glitch_start_busy got=%b exp=1", busy); end end
         if (n == 11) begin n_cmp++; if (busy !== 1'b1) begin n_err++; $display("FAIL glitch_presample_busy got=%b exp=1", busy); end end
         if (n == 12) begin n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL glitch_idle_busy got=%b exp=0", busy); end end
      end
      repeat (20) @(negedge clk);
      n_cmp += 2;
      if (busy !== 1'b0) begin n_err++; $display("FAIL glitch_late_busy got=%b exp=0", busy); end
      if (rx_valid !== 1'b0 || rise_cyc !== r0) begin n_err++; $display("FAIL glitch_valid got=%b exp=0", rx_valid); end
   endtask

   task automatic test_frame_err;
      int fe0;
      fe0 = fe_tot;
      send_frame(8'h3C, 1'b0);
      repeat (40) @(posedge clk);
      @(negedge clk);
      n_cmp += 3;
      if (fe_tot - fe0 !== 1) begin n_err++; $display("FAIL ferr_pulses got=%0d exp=1", fe_tot - fe0); end
      if (rx_valid !== 1'b0) begin n_err++; $display("FAIL ferr_valid got=%b exp=0", rx_valid); end
      if (busy !== 1'b1) begin n_err++; $display("FAIL ferr_break_busy got=%b exp=1", busy); end
      @(posedge clk) #1 rxd = 1'b1;
      for (int n = 1; n <= 4; n++) begin
         @(negedge clk);
         if (n == 3) begin n_cmp++; if (busy !== 1'b1) begin n_err++; $display("FAIL ferr_wait_busy got=%b exp=1", busy); end end
         if (n == 4) begin n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL ferr_idle_busy got=%b exp=0", busy); end end
      end
      repeat (8) @(posedge clk);
   endtask

   task automatic test_back_to_back;
      int ov0;
      ov0 = ov_tot;
      send_frame(8'h11, 1'b1);
      send_frame(8'h22, 1'b1);
      repeat (4) @(posedge clk);
      @(negedge clk);
      n_cmp += 3;
      if (rxdata !== 8'h22) begin n_err++; $display("FAIL b2b_data got=%h exp=22", rxdata); end
      if (ov_tot - ov0 !== 1) begin n_err++; $display("FAIL b2b_ovr got=%0d exp=1", ov_tot - ov0); end
      if (rx_valid !== 1'b1) begin n_err++; $display("FAIL b2b_valid got=%b exp=1", rx_valid); end
      ack_pulse();
      ov0 = ov_tot;
      fork
         begin
            send_frame(8'h11, 1'b1);
            send_frame(8'h22, 1'b1);
         end
         begin
            @(posedge clk);
            repeat (314) @(posedge clk);
            #1 rx_ack = 1'b1;
            @(posedge clk);
            #1 rx_ack = 1'b0;
         end
      join
      repeat (4) @(posedge clk);
      @(negedge clk);
      n_cmp += 3;
      if (rxdata !== 8'h22) begin n_err++; $display("FAIL b2b_ack_data got=%h exp=22", rxdata); end
      if (ov_tot - ov0 !== 0) begin n_err++; $display("FAIL b2b_ack_ovr got=%0d exp=0", ov_tot - ov0); end
      if (rx_valid !== 1'b1) begin n_err++; $display("FAIL b2b_ack_valid got=%b exp=1", rx_valid); end
   endtask

   task automatic test_reset_midframe;
      int fe0, ov0;
      fe0 = fe_tot; ov0 = ov_tot;
      fork
         send_frame(8'hFF, 1'b1);
         begin
            @(posedge clk);
            repeat (88) @(posedge clk);
            #1 rst = 1'b0;
            @(negedge clk);
            n_cmp += 5;
            if (rxdata !== 8'h00) begin n_err++; $display("FAIL rstmid_data got=%h exp=00", rxdata); end
            if (rx_valid !== 1'b0) begin n_err++; $display("FAIL rstmid_valid got=%b exp=0", rx_valid); end
            if (busy !== 1'b0) begin n_err++; $display("FAIL rstmid_busy got=%b exp=0", busy); end
            if (frame_err !== 1'b0) begin n_err++; $display("FAIL rstmid_ferr got=%b exp=0", frame_err); end
            if (overrun !== 1'b0) begin n_err++; $display("FAIL rstmid_ovr got=%b exp=0", overrun); end
            repeat (5) @(posedge clk);
            #1 rst = 1'b1;
         end
      join
      repeat (20) @(posedge clk);
      @(negedge clk);
      n_cmp += 2;
      if (rx_valid !== 1'b0) begin n_err++; $display("FAIL rstmid_after_valid got=%b exp=0", rx_valid); end
      if (busy !== 1'b0) begin n_err++; $display("FAIL rstmid_after_busy got=%b exp=0", busy); end
      send_frame(8'h0F, 1'b1);
      repeat (4) @(posedge clk);
      @(negedge clk);
      n_cmp += 4;
      if (rxdata !== 8'h0F) begin n_err++; $display("FAIL rstmid_next_data got=%h exp=0f", rxdata); end
      if (rx_valid !== 1'b1) begin n_err++; $display("FAIL rstmid_next_valid got=%b exp=1", rx_valid); end
      if (fe_tot - fe0 !== 0) begin n_err++; $display("FAIL rstmid_ferr_cnt got=%0d exp=0", fe_tot - fe0); end
      if (ov_tot - ov0 !== 0) begin n_err++; $display("FAIL rstmid_ovr_cnt got=%0d exp=0", ov_tot - ov0); end
   endtask

   initial begin
      repeat (3) @(posedge clk);
      test_reset();
      test_single();
      test_glitch();
      test_frame_err();
      test_back_to_back();
      test_reset_midframe();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule
